r_reorder_unit: RTL and testbench
=================================

Name: r_reorder_unit

Overview:
- Restores AXI read-response ordering before the outgoing R FIFO.
- Upstream AR logic allocates a tag per read burst, in request order. Slave R beats return tagged and in any order across tags.
- This block stores the beats per tag and releases whole bursts in allocation order. On release it replaces the tag with the original master ID and regenerates LAST.
- r_out feeds the outgoing response buffer.

Parameters:
- ID_WIDTH, 4: original master ID width; also the width of the r_in/r_out id field.
- DATA_WIDTH, 64: R data width.
- RESP_WIDTH, 2: R resp width.
- NUM_TAGS, 8: outstanding bursts; must be a power of 2 and at most 2**ID_WIDTH.
- TAG_WIDTH, $clog2(NUM_TAGS): tag width.
- MAX_BEATS, 4: maximum beats per burst; power of 2.
- LEN_WIDTH, $clog2(MAX_BEATS): width of the beats-minus-one field.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- alloc_valid  in  1  AR side requests a tag.
- alloc_ready  out  1  a tag is free.
- alloc_id  in  ID_WIDTH  original master ARID.
- alloc_len  in  LEN_WIDTH  burst beats minus 1.
- alloc_tag  out  TAG_WIDTH  tag granted on alloc fire; this is the ID sent to the slave.
- r_in  r_if.receiver  -  R beats from the slave; r_in.id[TAG_WIDTH-1:0] carries the tag.
- r_out  r_if.sender  -  reordered R beats to the outgoing response buffer.
- free_count  out  TAG_WIDTH+1  number of free tags.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (rst=0, async), all state cleared:
  - alloc_ready=1, alloc_tag=0, free_count=NUM_TAGS.
  - r_out.valid=0, r_in.ready=1, protocol_err=0.
  - alloc_ptr=0, head_ptr=0.
  - All tags FREE.
  - Reset mid-burst discards all stored beats. No partial burst is emitted after reset release.
- Per-tag state: FREE -> PENDING on alloc fire -> FREE when that tag's last beat pops at r_out.
  - Per tag stored: orig_id, len, wr_cnt (0..MAX_BEATS), and a MAX_BEATS x {data,resp} beat store.
- Allocation:
  - alloc_tag = alloc_ptr.
  - alloc_ready = (free_count != 0), computed from registered state only. A tag freed in cycle N is allocatable from N+1.
  - On fire: capture id/len, wr_cnt=0, state PENDING, alloc_ptr += 1 mod NUM_TAGS.
- R input:
  - r_in.ready is always 1.
  - Beat with tag t is accepted if state[t]==PENDING and wr_cnt[t] <= len[t]. It is written to slot wr_cnt[t], and wr_cnt[t] increments.
  - Error cases (beat is dropped and protocol_err is set):
    - beat to a FREE tag;
    - beat beyond len;
    - r_in.last disagreeing with (wr_cnt==len).
  - protocol_err clears only on reset.
- Release (cut-through):
  - Only the head tag h=head_ptr is eligible, read at beat rd_cnt.
  - r_out.valid = state[h]==PENDING & rd_cnt < wr_cnt[h].
  - r_out.id = orig_id[h]; data/resp come from slot rd_cnt; r_out.last = (rd_cnt==len[h]).
  - A beat written in cycle N can appear on r_out in N+1 (registered store, no same-cycle bypass).
  - r_out fields hold stable while valid & ~ready.
  - On pop: rd_cnt += 1. On a last pop: rd_cnt=0, state[h]=FREE, head_ptr += 1 mod NUM_TAGS.
- Simultaneous events:
  - Alloc, r_in write and r_out pop may all fire in one cycle.
  - free_count net change is -1 (alloc only), +1 (release only), or 0 (both).
  - A write to the head tag at the slot currently being popped cannot happen, because rd_cnt < wr_cnt.
- Full/empty:
  - free_count==0 holds off alloc_ready.
  - free_count==NUM_TAGS forces r_out.valid=0.
  - Pointers wrap NUM_TAGS-1 -> 0.
- Width rules:
  - Counters are LEN_WIDTH+1 bits; all arithmetic is unsigned, with wrap by explicit compare.
  - IDs wider than TAG_WIDTH are zero-extended when emitted to the slave.

Decomposition:
- Package rob_r_pkg holds:
  - r_beat_t struct {data, resp};
  - tag_ctx_t struct {orig_id, len, wr_cnt, state};
  - tag_state_e enum {TAG_FREE, TAG_PENDING};
  - NUM_TAGS/MAX_BEATS defaults.
- Sub-module r_beat_store: NUM_TAGS*MAX_BEATS entries of r_beat_t, one write port (tag, slot) and one combinational read port (head, rd_cnt). The top holds tag context, pointers and handshake.

Test Plan:
- In-order single burst:
  - Stimulus: alloc id=5 len=3 -> tag 0; slave sends 4 beats tag 0, data 0xA0..0xA3.
  - Required: r_out emits id=5, data 0xA0..0xA3, last only on the 4th; free_count returns to 8.
- Out-of-order bursts:
  - Stimulus: alloc id=2 len=1 (tag 0), then id=7 len=0 (tag 1); slave sends tag 1 first, then tag 0.
  - Required: r_out emits id=2 x2 beats, then id=7 x1; no tag-1 beat before tag 0 completes.
- Full:
  - Stimulus: 8 allocs with no responses.
  - Required: alloc_ready=0 and free_count=0. Completing and popping tag 0 raises alloc_ready the following cycle; the next alloc_tag=0 (wrap).
- Backpressure:
  - Stimulus: r_out.ready=0 for 5 cycles mid-burst.
  - Required: r_out.valid stays 1 with id/data/last stable; no beat is lost or duplicated after ready returns.
- Protocol error:
  - Stimulus: beat to a FREE tag 3, or a 3rd beat to a len=1 tag.
  - Required: beat dropped, protocol_err=1 and sticky, other bursts unaffected.
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously with 2 tags holding partial data.
  - Required: outputs reach reset values immediately; after release r_out.valid=0 and free_count=8.

Source files
------------

// File: rtl/r_reorder_unit_pkg.sv
// Shared types and default sizes for the R-channel reorder unit.
// Struct field widths follow the DEF_* sizes; the top's parameters default to the same values.
package rob_r_pkg;

  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_RESP_WIDTH = 2;
  localparam int DEF_NUM_TAGS   = 8;
  localparam int DEF_MAX_BEATS  = 4;
  localparam int DEF_TAG_WIDTH  = $clog2(DEF_NUM_TAGS);
  localparam int DEF_LEN_WIDTH  = $clog2(DEF_MAX_BEATS);

  typedef enum logic {
    TAG_FREE    = 1'b0,
    TAG_PENDING = 1'b1
  } tag_state_e;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_RESP_WIDTH-1:0] resp;
  } r_beat_t;

  typedef struct packed {
    logic [DEF_ID_WIDTH-1:0]  orig_id;
    logic [DEF_LEN_WIDTH-1:0] len;
    logic [DEF_LEN_WIDTH:0]   wr_cnt;
    tag_state_e               state;
  } tag_ctx_t;

endpackage

// File: rtl/r_reorder_unit_if.sv
// AXI R-channel bundle; the receiver takes beats in, the sender pushes them out.
interface r_if #(
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
) ();

  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;

  modport receiver (
    input  valid, id, data, resp, last,
    output ready
  );

  modport sender (
    output valid, id, data, resp, last,
    input  ready
  );

endinterface

// File: rtl/r_reorder_unit_beat_store.sv
// Per-tag beat storage: one registered write port, one combinational read port.
// No reset: contents only become visible through the top's per-tag wr_cnt, which reset clears.
module r_beat_store
  import rob_r_pkg::*;
#(
  parameter int NUM_TAGS  = DEF_NUM_TAGS,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int TAG_WIDTH = $clog2(NUM_TAGS),
  parameter int LEN_WIDTH = $clog2(MAX_BEATS)
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [TAG_WIDTH-1:0] wr_tag,
  input  logic [LEN_WIDTH-1:0] wr_slot,
  input  r_beat_t              wr_beat,
  input  logic [TAG_WIDTH-1:0] rd_tag,
  input  logic [LEN_WIDTH-1:0] rd_slot,
  output r_beat_t              rd_beat
);

  localparam int DEPTH  = NUM_TAGS * MAX_BEATS;
  localparam int ADDR_W = TAG_WIDTH + LEN_WIDTH;

  r_beat_t           mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  assign wr_addr = {wr_tag, wr_slot};
  assign rd_addr = {rd_tag, rd_slot};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_beat;
    end
  end

  assign rd_beat = mem_q[rd_addr];

endmodule

// File: rtl/r_reorder_unit.sv
// Reorders tagged AXI R beats back into tag-allocation order, restoring the master ID
// and regenerating LAST as each whole burst is released.
module r_reorder_unit
  import rob_r_pkg::*;
#(
  parameter int ID_WIDTH   = DEF_ID_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RESP_WIDTH = DEF_RESP_WIDTH,
  parameter int NUM_TAGS   = DEF_NUM_TAGS,
  parameter int TAG_WIDTH  = $clog2(NUM_TAGS),
  parameter int MAX_BEATS  = DEF_MAX_BEATS,
  parameter int LEN_WIDTH  = $clog2(MAX_BEATS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  input  logic [ID_WIDTH-1:0]  alloc_id,
  input  logic [LEN_WIDTH-1:0] alloc_len,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  r_if.receiver                r_in,
  r_if.sender                  r_out,
  output logic [TAG_WIDTH:0]   free_count,
  output logic                 protocol_err
);

  localparam logic [TAG_WIDTH-1:0] LAST_TAG   = TAG_WIDTH'(NUM_TAGS - 1);
  localparam logic [TAG_WIDTH-1:0] PTR_ONE    = TAG_WIDTH'(1);
  localparam logic [TAG_WIDTH:0]   FULL_COUNT = (TAG_WIDTH + 1)'(NUM_TAGS);
  localparam logic [TAG_WIDTH:0]   FREE_ONE   = (TAG_WIDTH + 1)'(1);
  localparam logic [LEN_WIDTH:0]   CNT_ONE    = (LEN_WIDTH + 1)'(1);
  localparam tag_ctx_t             CTX_RESET  = '{orig_id: '0, len: '0, wr_cnt: '0, state: TAG_FREE};

  tag_ctx_t             ctx_q [NUM_TAGS];
  tag_ctx_t             ctx_d [NUM_TAGS];
  logic [TAG_WIDTH-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [TAG_WIDTH-1:0] head_ptr_q, head_ptr_d;
  logic [LEN_WIDTH:0]   rd_cnt_q, rd_cnt_d;
  logic [TAG_WIDTH:0]   free_count_q, free_count_d;
  logic                 protocol_err_q, protocol_err_d;

  logic                  alloc_fire;
  logic [TAG_WIDTH-1:0]  in_tag;
  tag_ctx_t              in_ctx;
  logic                  in_accept;
  logic [DATA_WIDTH-1:0] in_data;
  logic [RESP_WIDTH-1:0] in_resp;
  r_beat_t               wr_beat;
  tag_ctx_t              head_ctx;
  r_beat_t               rd_beat;
  logic                  out_valid;
  logic                  out_last;
  logic                  pop;
  logic                  last_pop;

  // alloc_ready depends only on registered state, so a freed tag is grantable next cycle
  assign alloc_ready = (free_count_q != '0);
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_tag   = alloc_ptr_q;

  assign in_tag    = r_in.id[TAG_WIDTH-1:0];
  assign in_ctx    = ctx_q[in_tag];
  assign in_accept = (in_ctx.state == TAG_PENDING)
                   && (in_ctx.wr_cnt <= {1'b0, in_ctx.len})
                   && (r_in.last == (in_ctx.wr_cnt == {1'b0, in_ctx.len}));
  assign in_data   = r_in.data;
  assign in_resp   = r_in.resp;
  assign wr_beat   = '{data: in_data, resp: in_resp};

  generate
    if (ID_WIDTH > TAG_WIDTH) begin : g_id_hi
      logic unused_id_hi;
      assign unused_id_hi = ^r_in.id[ID_WIDTH-1:TAG_WIDTH];
    end
  endgenerate

  r_beat_store #(
    .NUM_TAGS  (NUM_TAGS),
    .MAX_BEATS (MAX_BEATS),
    .TAG_WIDTH (TAG_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_store (
    .clk     (clk),
    .wr_en   (r_in.valid & in_accept),
    .wr_tag  (in_tag),
    .wr_slot (in_ctx.wr_cnt[LEN_WIDTH-1:0]),
    .wr_beat (wr_beat),
    .rd_tag  (head_ptr_q),
    .rd_slot (rd_cnt_q[LEN_WIDTH-1:0]),
    .rd_beat (rd_beat)
  );

  // Only the head tag may drain; rd_cnt < wr_cnt keeps the read slot already written
  assign head_ctx  = ctx_q[head_ptr_q];
  assign out_valid = (head_ctx.state == TAG_PENDING) && (rd_cnt_q < head_ctx.wr_cnt)
                   && (free_count_q != FULL_COUNT);
  assign out_last  = (rd_cnt_q == {1'b0, head_ctx.len});
  assign pop       = out_valid & r_out.ready;
  assign last_pop  = pop & out_last;

  assign r_in.ready   = 1'b1;
  assign r_out.valid  = out_valid;
  assign r_out.id     = head_ctx.orig_id;
  assign r_out.data   = rd_beat.data;
  assign r_out.resp   = rd_beat.resp;
  assign r_out.last   = out_last;
  assign free_count   = free_count_q;
  assign protocol_err = protocol_err_q;

  always_comb begin
    ctx_d          = ctx_q;
    alloc_ptr_d    = alloc_ptr_q;
    head_ptr_d     = head_ptr_q;
    rd_cnt_d       = rd_cnt_q;
    free_count_d   = free_count_q;
    protocol_err_d = protocol_err_q;

    if (alloc_fire) begin
      ctx_d[alloc_ptr_q] = '{orig_id: alloc_id, len: alloc_len, wr_cnt: '0, state: TAG_PENDING};
      alloc_ptr_d        = (alloc_ptr_q == LAST_TAG) ? '0 : alloc_ptr_q + PTR_ONE;
    end

    if (r_in.valid) begin
      if (in_accept) begin
        ctx_d[in_tag].wr_cnt = in_ctx.wr_cnt + CNT_ONE;
      end else begin
        protocol_err_d = 1'b1;
      end
    end

    // A completed burst has wr_cnt == len+1, so no write can target the tag freed here
    if (last_pop) begin
      ctx_d[head_ptr_q].state = TAG_FREE;
      rd_cnt_d                = '0;
      head_ptr_d              = (head_ptr_q == LAST_TAG) ? '0 : head_ptr_q + PTR_ONE;
    end else if (pop) begin
      rd_cnt_d = rd_cnt_q + CNT_ONE;
    end

    unique case ({alloc_fire, last_pop})
      2'b10:   free_count_d = free_count_q - FREE_ONE;
      2'b01:   free_count_d = free_count_q + FREE_ONE;
      default: free_count_d = free_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        ctx_q[i] <= CTX_RESET;
      end
      alloc_ptr_q    <= '0;
      head_ptr_q     <= '0;
      rd_cnt_q       <= '0;
      free_count_q   <= FULL_COUNT;
      protocol_err_q <= 1'b0;
    end else begin
      ctx_q          <= ctx_d;
      alloc_ptr_q    <= alloc_ptr_d;
      head_ptr_q     <= head_ptr_d;
      rd_cnt_q       <= rd_cnt_d;
      free_count_q   <= free_count_d;
      protocol_err_q <= protocol_err_d;
    end
  end

endmodule

// File: tb/tb_r_reorder_unit.sv
// Directed self-checking bench for r_reorder_unit: ordering, full, backpressure, errors, reset.
module tb_r_reorder_unit;

  localparam int ID_W   = 4;
  localparam int DATA_W = 64;
  localparam int RESP_W = 2;
  localparam int TAG_W  = 3;
  localparam int LEN_W  = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [ID_W-1:0]  alloc_id;
  logic [LEN_W-1:0] alloc_len;
  logic [TAG_W-1:0] alloc_tag;
  logic [TAG_W:0]   free_count;
  logic             protocol_err;

  int check_count = 0;
  int pass_count  = 0;

  r_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DATA_W), .RESP_WIDTH(RESP_W)) r_in_if ();
  r_if #(.ID_WIDTH(ID_W), .DATA_WIDTH(DATA_W), .RESP_WIDTH(RESP_W)) r_out_if ();

  r_reorder_unit dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_ready  (alloc_ready),
    .alloc_id     (alloc_id),
    .alloc_len    (alloc_len),
    .alloc_tag    (alloc_tag),
    .r_in         (r_in_if),
    .r_out        (r_out_if),
    .free_count   (free_count),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic do_alloc(input string name, input logic [ID_W-1:0] id,
                          input logic [LEN_W-1:0] len, input logic [TAG_W-1:0] exp_tag);
    check_output({name, ".ready"}, alloc_ready, 1);
    check_output({name, ".tag"}, alloc_tag, exp_tag);
    alloc_valid = 1'b1;
    alloc_id    = id;
    alloc_len   = len;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [TAG_W-1:0] tag, input logic [63:0] data, input logic last);
    r_in_if.valid = 1'b1;
    r_in_if.id    = {1'b0, tag};
    r_in_if.data  = data;
    r_in_if.resp  = data[1:0];
    r_in_if.last  = last;
    step();
    r_in_if.valid = 1'b0;
    r_in_if.last  = 1'b0;
  endtask

  // Waits (bounded) for a beat at r_out, checks it, then pops it with a one-cycle ready
  task automatic expect_pop(input string name, input logic [ID_W-1:0] id,
                            input logic [63:0] data, input logic last);
    int n = 0;
    while (!r_out_if.valid && n < 20) begin
      step();
      n++;
    end
    check_output({name, ".valid"}, r_out_if.valid, 1);
    check_output({name, ".id"}, r_out_if.id, id);
    check_output({name, ".data"}, r_out_if.data, data);
    check_output({name, ".resp"}, r_out_if.resp, data[1:0]);
    check_output({name, ".last"}, r_out_if.last, last);
    r_out_if.ready = 1'b1;
    step();
    r_out_if.ready = 1'b0;
  endtask

  initial begin
    logic [63:0] held_data;
    alloc_valid    = 1'b0;
    alloc_id       = '0;
    alloc_len      = '0;
    r_in_if.valid  = 1'b0;
    r_in_if.id     = '0;
    r_in_if.data   = '0;
    r_in_if.resp   = '0;
    r_in_if.last   = 1'b0;
    r_out_if.ready = 1'b0;

    $display("[TB] reset state");
    do_reset();
    check_output("rst.alloc_ready", alloc_ready, 1);
    check_output("rst.alloc_tag", alloc_tag, 0);
    check_output("rst.free_count", free_count, 8);
    check_output("rst.out_valid", r_out_if.valid, 0);
    check_output("rst.in_ready", r_in_if.ready, 1);
    check_output("rst.protocol_err", protocol_err, 0);

    $display("[TB] in-order single burst");
    do_alloc("t1.alloc", 4'd5, 2'd3, 3'd0);
    check_output("t1.free_after_alloc", free_count, 7);
    for (int i = 0; i < 4; i++) send_beat(3'd0, 64'hA0 + 64'(i), i == 3);
    for (int i = 0; i < 4; i++) expect_pop($sformatf("t1.pop%0d", i), 4'd5, 64'hA0 + 64'(i), i == 3);
    check_output("t1.free_end", free_count, 8);
    check_output("t1.idle", r_out_if.valid, 0);

    $display("[TB] out-of-order bursts");
    do_reset();
    do_alloc("t2.alloc0", 4'd2, 2'd1, 3'd0);
    do_alloc("t2.alloc1", 4'd7, 2'd0, 3'd1);
    send_beat(3'd1, 64'h71, 1'b1);
    step();
    check_output("t2.hold_tag1", r_out_if.valid, 0);
    send_beat(3'd0, 64'h20, 1'b0);
    send_beat(3'd0, 64'h21, 1'b1);
    expect_pop("t2.pop0", 4'd2, 64'h20, 1'b0);
    expect_pop("t2.pop1", 4'd2, 64'h21, 1'b1);
    expect_pop("t2.pop2", 4'd7, 64'h71, 1'b1);
    check_output("t2.free_end", free_count, 8);
    check_output("t2.err", protocol_err, 0);

    $display("[TB] full and wrap");
    do_reset();
    for (int i = 0; i < 8; i++) do_alloc($sformatf("t3.alloc%0d", i), 4'(i), 2'd0, 3'(i));
    check_output("t3.full_ready", alloc_ready, 0);
    check_output("t3.full_count", free_count, 0);
    send_beat(3'd0, 64'h55, 1'b1);
    check_output("t3.still_full", alloc_ready, 0);
    expect_pop("t3.pop", 4'd0, 64'h55, 1'b1);
    check_output("t3.ready_back", alloc_ready, 1);
    check_output("t3.count_back", free_count, 1);
    do_alloc("t3.wrap", 4'd9, 2'd0, 3'd0);
    check_output("t3.full_again", free_count, 0);

    $display("[TB] backpressure");
    do_reset();
    do_alloc("t4.alloc", 4'd3, 2'd3, 3'd0);
    send_beat(3'd0, 64'hB0, 1'b0);
    send_beat(3'd0, 64'hB1, 1'b0);
    expect_pop("t4.pop0", 4'd3, 64'hB0, 1'b0);
    held_data = 64'hB1;
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("t4.stall%0d.valid", i), r_out_if.valid, 1);
      check_output($sformatf("t4.stall%0d.id", i), r_out_if.id, 3);
      check_output($sformatf("t4.stall%0d.data", i), r_out_if.data, held_data);
      check_output($sformatf("t4.stall%0d.last", i), r_out_if.last, 0);
      if (i == 1) send_beat(3'd0, 64'hB2, 1'b0);
      else if (i == 2) send_beat(3'd0, 64'hB3, 1'b1);
      else step();
    end
    expect_pop("t4.pop1", 4'd3, 64'hB1, 1'b0);
    expect_pop("t4.pop2", 4'd3, 64'hB2, 1'b0);
    expect_pop("t4.pop3", 4'd3, 64'hB3, 1'b1);
    check_output("t4.no_dup", r_out_if.valid, 0);
    check_output("t4.free_end", free_count, 8);

    $display("[TB] protocol errors");
    do_reset();
    do_alloc("t5.alloc", 4'd4, 2'd1, 3'd0);
    send_beat(3'd3, 64'hEE, 1'b1);
    check_output("t5.err_free_tag", protocol_err, 1);
    check_output("t5.dropped", r_out_if.valid, 0);
    send_beat(3'd0, 64'hC0, 1'b0);
    send_beat(3'd0, 64'hC1, 1'b1);
    send_beat(3'd0, 64'hCC, 1'b1);
    expect_pop("t5.pop0", 4'd4, 64'hC0, 1'b0);
    expect_pop("t5.pop1", 4'd4, 64'hC1, 1'b1);
    check_output("t5.extra_dropped", r_out_if.valid, 0);
    check_output("t5.sticky", protocol_err, 1);
    check_output("t5.free_end", free_count, 8);

    $display("[TB] reset mid-operation");
    do_alloc("t6.alloc0", 4'd1, 2'd3, 3'd1);
    do_alloc("t6.alloc1", 4'd6, 2'd3, 3'd2);
    send_beat(3'd1, 64'hD0, 1'b0);
    send_beat(3'd2, 64'hE0, 1'b0);
    check_output("t6.pre_valid", r_out_if.valid, 1);
    check_output("t6.pre_count", free_count, 6);
    rst = 1'b0;
    #1;
    check_output("t6.async_valid", r_out_if.valid, 0);
    check_output("t6.async_count", free_count, 8);
    check_output("t6.async_err", protocol_err, 0);
    check_output("t6.async_tag", alloc_tag, 0);
    step();
    rst = 1'b1;
    step();
    step();
    check_output("t6.post_valid", r_out_if.valid, 0);
    check_output("t6.post_count", free_count, 8);
    check_output("t6.post_ready", alloc_ready, 1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
